// File: rtl/vx_mem_latency_pkg.sv
// Shared types and helpers for the latency RAM responder.
//
// The response-entry struct depends on module parameters, so it is provided as
// a macro that each user expands inside its own parameter scope:
//   `VX_MEM_RSP_ENTRY_T(TW, DW) -> typedef struct packed {tag, data} rsp_entry_t;
// BYTEEN_WIDTH / CREDIT_WIDTH are given for the default configuration; the
// byteen_width()/credit_width() functions derive them for any other one.
// store_index() folds a word address onto the backing-store depth.

`ifndef VX_MEM_LATENCY_PKG_SV
`define VX_MEM_LATENCY_PKG_SV

`define VX_MEM_RSP_ENTRY_T(TW, DW) \
    typedef struct packed { \
        logic [(TW)-1:0] tag; \
        logic [(DW)-1:0] data; \
    } rsp_entry_t;

package vx_mem_latency_pkg;

    localparam int DEF_DATA_WIDTH      = 512;
    localparam int DEF_RSP_QUEUE_DEPTH = 4;

    localparam int BYTEEN_WIDTH = DEF_DATA_WIDTH / 8;
    localparam int CREDIT_WIDTH = $clog2(DEF_RSP_QUEUE_DEPTH + 1);

    function automatic int byteen_width(input int data_width);
        return data_width / 8;
    endfunction

    // One extra code point so that "all DEPTH credits in use" is representable.
    function automatic int credit_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Upper address bits are dropped, so addresses alias modulo the store depth.
    // A narrower address is zero-extended by the 64-bit argument.
    function automatic logic [31:0] store_index(input logic [63:0] addr,
                                                input int          words_log2);
        logic [63:0] mask;
        mask = (64'd1 << words_log2) - 64'd1;
        return 32'(addr & mask);
    endfunction

endpackage

`endif

// File: rtl/vx_mem_rsp_fifo.sv
// Synchronous FIFO that holds responses waiting for the consumer.
//
// Ports:
//   clk, rst_n        clock, async active-low reset (clears pointers only)
//   push_i, din_i     write an entry
//   pop_i             drop the head entry
//   dout_o            head entry (valid while !empty_o)
//   empty_o, full_o   occupancy flags
//
// Pointers carry one extra wrap bit so full and empty are distinguishable.

module vx_mem_rsp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign dout_o  = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push_i) wptr_d = wptr_q + 1'b1;
        if (pop_i)  rptr_d = rptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset: entries are only observed after being written.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wptr_q[AW-1:0]] <= din_i;
    end

    // The upstream credit scheme guarantees these never happen.
    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
                                     !(push_i && full_o));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
                                     !(pop_i && empty_o));

endmodule

// File: rtl/vx_mem_latency_ram.sv
// Fixed-latency memory responder for a core memory port.
//
// Ports:
//   clk, reset                 clock, async active-low reset
//   mem_req_valid/_ready       request handshake
//   mem_req_rw                 1 = write, 0 = read
//   mem_req_byteen/_addr/_data write byte enables, word address, write data
//   mem_req_tag                request tag, echoed on the response
//   mem_rsp_valid/_ready       response handshake
//   mem_rsp_data/_tag          response payload (data is zero for write acks)
//   busy                       at least one response outstanding
//
// Flow: accepted request -> (LATENCY-1)-stage delay line -> response FIFO.
// The delay line never stalls; a credit counter covering both the line and the
// FIFO throttles requests so the FIFO can never overflow.

module vx_mem_latency_ram
    import vx_mem_latency_pkg::*;
#(
    parameter int DATA_WIDTH      = 512,
    parameter int ADDR_WIDTH      = 26,
    parameter int TAG_WIDTH       = 8,
    parameter int MEM_WORDS_LOG2  = 12,
    parameter int LATENCY         = 4,
    parameter int RSP_QUEUE_DEPTH = 4,
    parameter int WRITE_RSP       = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mem_req_valid,
    input  logic                      mem_req_rw,
    input  logic [DATA_WIDTH/8-1:0]   mem_req_byteen,
    input  logic [ADDR_WIDTH-1:0]     mem_req_addr,
    input  logic [DATA_WIDTH-1:0]     mem_req_data,
    input  logic [TAG_WIDTH-1:0]      mem_req_tag,
    output logic                      mem_req_ready,
    output logic                      mem_rsp_valid,
    output logic [DATA_WIDTH-1:0]     mem_rsp_data,
    output logic [TAG_WIDTH-1:0]      mem_rsp_tag,
    input  logic                      mem_rsp_ready,
    output logic                      busy
);

    localparam int BE_W    = byteen_width(DATA_WIDTH);
    localparam int CR_W    = credit_width(RSP_QUEUE_DEPTH);
    localparam int WORDS   = 1 << MEM_WORDS_LOG2;
    localparam int ENTRY_W = TAG_WIDTH + DATA_WIDTH;

    `VX_MEM_RSP_ENTRY_T(TAG_WIDTH, DATA_WIDTH)

    // Backing store: never reset, starts at zero in simulation.
    logic [DATA_WIDTH-1:0] store_q [WORDS] = '{default: '0};

    logic [MEM_WORDS_LOG2-1:0] idx;
    logic [CR_W-1:0]           credits_q, credits_d;
    logic                      req_fire, req_has_rsp, rsp_push, rsp_fire;
    rsp_entry_t                req_entry;
    logic                      dl_out_vld;
    rsp_entry_t                dl_out;
    logic                      fifo_empty, fifo_full;
    rsp_entry_t                fifo_head;

    assign idx = MEM_WORDS_LOG2'(store_index(64'(mem_req_addr), MEM_WORDS_LOG2));

    // Held low for the whole reset pulse; otherwise purely a credit check.
    assign mem_req_ready = reset && (credits_q < CR_W'(RSP_QUEUE_DEPTH));
    assign req_fire      = mem_req_valid && mem_req_ready;
    assign req_has_rsp   = !mem_req_rw || (WRITE_RSP != 0);
    assign rsp_push      = req_fire && req_has_rsp;

    // Read data is taken in the accept cycle, so a later write cannot leak in.
    assign req_entry.tag  = mem_req_tag;
    assign req_entry.data = mem_req_rw ? '0 : store_q[idx];

    always_ff @(posedge clk) begin
        if (req_fire && mem_req_rw) begin
            for (int b = 0; b < BE_W; b++) begin
                if (mem_req_byteen[b]) store_q[idx][b*8 +: 8] <= mem_req_data[b*8 +: 8];
            end
        end
    end

    // Delay line: LATENCY-1 stages plus the FIFO register gives LATENCY cycles.
    generate
        if (LATENCY > 1) begin : g_dl
            localparam int STAGES = LATENCY - 1;
            logic [STAGES-1:0] vld_pipe_q;
            rsp_entry_t        dl_q [STAGES];

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    vld_pipe_q <= '0;
                    for (int s = 0; s < STAGES; s++) dl_q[s] <= '0;
                end else begin
                    vld_pipe_q[0] <= rsp_push;
                    dl_q[0]       <= req_entry;
                    for (int s = 1; s < STAGES; s++) begin
                        vld_pipe_q[s] <= vld_pipe_q[s-1];
                        dl_q[s]       <= dl_q[s-1];
                    end
                end
            end

            assign dl_out_vld = vld_pipe_q[STAGES-1];
            assign dl_out     = dl_q[STAGES-1];
        end else begin : g_no_dl
            assign dl_out_vld = rsp_push;
            assign dl_out     = req_entry;
        end
    endgenerate

    vx_mem_rsp_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (RSP_QUEUE_DEPTH)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (dl_out_vld),
        .din_i   (dl_out),
        .pop_i   (rsp_fire),
        .dout_o  (fifo_head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign mem_rsp_valid = !fifo_empty;
    assign rsp_fire      = mem_rsp_valid && mem_rsp_ready;
    // Gate stale FIFO contents so an idle port shows zeros.
    assign mem_rsp_data  = mem_rsp_valid ? fifo_head.data : '0;
    assign mem_rsp_tag   = mem_rsp_valid ? fifo_head.tag  : '0;

    // One credit per response in the delay line or FIFO.
    always_comb begin
        credits_d = credits_q;
        case ({rsp_push, rsp_fire})
            2'b10:   credits_d = credits_q + CR_W'(1);
            2'b01:   credits_d = credits_q - CR_W'(1);
            default: credits_d = credits_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) credits_q <= '0;
        else        credits_q <= credits_d;
    end

    assign busy = (credits_q != '0);

    // fifo_full is implied by credits; exposed only for the FIFO's own checks.
    logic unused_ok;
    assign unused_ok = fifo_full;

endmodule

// File: tb/tb_vx_mem_latency_ram.sv
// Scoreboard bench for vx_mem_latency_ram: the driver pushes hand-computed
// expected responses on accept; an independent monitor pops and compares on
// every response handshake and also checks hold-under-back-pressure.

module tb_vx_mem_latency_ram;

    localparam int DW   = 32;
    localparam int AW   = 8;
    localparam int TW   = 8;
    localparam int LOG2 = 4;
    localparam int LAT  = 4;
    localparam int QD   = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          mem_req_valid = 1'b0;
    logic          mem_req_rw = 1'b0;
    logic [DW/8-1:0] mem_req_byteen = '0;
    logic [AW-1:0] mem_req_addr = '0;
    logic [DW-1:0] mem_req_data = '0;
    logic [TW-1:0] mem_req_tag = '0;
    logic          mem_req_ready;
    logic          mem_rsp_valid;
    logic [DW-1:0] mem_rsp_data;
    logic [TW-1:0] mem_rsp_tag;
    logic          mem_rsp_ready = 1'b1;
    logic          busy;

    vx_mem_latency_ram #(
        .DATA_WIDTH      (DW),
        .ADDR_WIDTH      (AW),
        .TAG_WIDTH       (TW),
        .MEM_WORDS_LOG2  (LOG2),
        .LATENCY         (LAT),
        .RSP_QUEUE_DEPTH (QD),
        .WRITE_RSP       (0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_req_valid  (mem_req_valid),
        .mem_req_rw     (mem_req_rw),
        .mem_req_byteen (mem_req_byteen),
        .mem_req_addr   (mem_req_addr),
        .mem_req_data   (mem_req_data),
        .mem_req_tag    (mem_req_tag),
        .mem_req_ready  (mem_req_ready),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .mem_rsp_tag    (mem_rsp_tag),
        .mem_rsp_ready  (mem_rsp_ready),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
        int            cyc;   // -1 = latency not checked
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: samples mid-cycle, after the driver's negedge updates.
    initial begin
        exp_t          e;
        logic          prev_hold;
        logic [DW-1:0] prev_data;
        logic [TW-1:0] prev_tag;
        prev_hold = 1'b0;
        prev_data = '0;
        prev_tag  = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!reset) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    chk("hold_valid", 64'(mem_rsp_valid), 64'd1);
                    chk("hold_data", 64'(mem_rsp_data), 64'(prev_data));
                    chk("hold_tag", 64'(mem_rsp_tag), 64'(prev_tag));
                end
                if (mem_rsp_valid && mem_rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rsp: got tag %0h data %0h, expected no response",
                                 mem_rsp_tag, mem_rsp_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_tag", 64'(mem_rsp_tag), 64'(e.tag));
                        chk("rsp_data", 64'(mem_rsp_data), 64'(e.data));
                        if (e.cyc >= 0) chk("rsp_latency", 64'(cyc), 64'(e.cyc));
                    end
                end
                prev_hold = mem_rsp_valid && !mem_rsp_ready;
                prev_data = mem_rsp_data;
                prev_tag  = mem_rsp_tag;
            end
        end
    end

    task automatic req(input logic rw, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                       input logic [DW/8-1:0] be, input logic [TW-1:0] tag,
                       input logic [DW-1:0] exp_data, input bit push_exp, input bit chk_lat);
        int n;
        n = 0;
        @(negedge clk);
        mem_req_valid  = 1'b1;
        mem_req_rw     = rw;
        mem_req_addr   = addr;
        mem_req_data   = data;
        mem_req_byteen = be;
        mem_req_tag    = tag;
        while (!mem_req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!mem_req_ready) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: ready got 0, expected 1 within 50 cycles");
            mem_req_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            mem_req_valid = 1'b0;
            if (push_exp) exp_q.push_back('{tag, exp_data, chk_lat ? cyc + LAT - 1 : -1});
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || mem_rsp_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", 64'(mem_req_ready), 64'd0);
        chk("rst_valid", 64'(mem_rsp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_data", 64'(mem_rsp_data), 64'd0);
        chk("rst_tag", 64'(mem_rsp_tag), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 64'(mem_req_ready), 64'd1);

        // Read latency
        req(1'b1, 8'h10, 32'hA5A5A5A5, 4'hF, 8'h01, '0, 1'b0, 1'b0);
        req(1'b0, 8'h10, '0, 4'h0, 8'h03, 32'hA5A5A5A5, 1'b1, 1'b1);

        // Byte enables
        req(1'b1, 8'h05, 32'hFFFFFFFF, 4'hF, 8'h02, '0, 1'b0, 1'b0);
        req(1'b1, 8'h05, 32'h00000000, 4'b0001, 8'h02, '0, 1'b0, 1'b0);
        req(1'b0, 8'h05, '0, 4'h0, 8'h05, 32'hFFFFFF00, 1'b1, 1'b1);

        // Read-before-write, back to back
        req(1'b1, 8'h07, 32'h11223344, 4'hF, 8'h06, '0, 1'b0, 1'b0);
        req(1'b0, 8'h07, '0, 4'h0, 8'h07, 32'h11223344, 1'b1, 1'b1);
        req(1'b1, 8'h07, 32'hDEADBEEF, 4'hF, 8'h06, '0, 1'b0, 1'b0);
        req(1'b0, 8'h07, '0, 4'h0, 8'h08, 32'hDEADBEEF, 1'b1, 1'b1);

        // Aliasing: 0x13 and 0x03 share index 3
        req(1'b1, 8'h13, 32'hCAFEF00D, 4'hF, 8'h06, '0, 1'b0, 1'b0);
        req(1'b0, 8'h03, '0, 4'h0, 8'h09, 32'hCAFEF00D, 1'b1, 1'b1);
        drain("drain_basic");

        // Back-pressure: 4 credits then ready drops
        @(negedge clk);
        mem_rsp_ready = 1'b0;
        req(1'b0, 8'h03, '0, 4'h0, 8'h20, 32'hCAFEF00D, 1'b1, 1'b0);
        req(1'b0, 8'h05, '0, 4'h0, 8'h21, 32'hFFFFFF00, 1'b1, 1'b0);
        req(1'b0, 8'h07, '0, 4'h0, 8'h22, 32'hDEADBEEF, 1'b1, 1'b0);
        chk("bp_ready_3", 64'(mem_req_ready), 64'd1);
        req(1'b0, 8'h00, '0, 4'h0, 8'h23, 32'hA5A5A5A5, 1'b1, 1'b0);
        chk("bp_ready_4", 64'(mem_req_ready), 64'd0);
        chk("bp_busy", 64'(busy), 64'd1);
        fork
            begin
                repeat (8) @(negedge clk);
                chk("bp_valid_held", 64'(mem_rsp_valid), 64'd1);
                chk("bp_ready_held", 64'(mem_req_ready), 64'd0);
                mem_rsp_ready = 1'b1;
            end
            begin
                req(1'b0, 8'h13, '0, 4'h0, 8'h24, 32'hCAFEF00D, 1'b1, 1'b0);
                req(1'b0, 8'h15, '0, 4'h0, 8'h25, 32'hFFFFFF00, 1'b1, 1'b0);
            end
        join
        drain("drain_bp");
        chk("bp_ready_after", 64'(mem_req_ready), 64'd1);

        // Reset with three reads in flight
        req(1'b0, 8'h03, '0, 4'h0, 8'h30, '0, 1'b0, 1'b0);
        req(1'b0, 8'h05, '0, 4'h0, 8'h31, '0, 1'b0, 1'b0);
        req(1'b0, 8'h07, '0, 4'h0, 8'h32, '0, 1'b0, 1'b0);
        chk("mid_busy_before", 64'(busy), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(mem_rsp_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_ready", 64'(mem_req_ready), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_post_ready", 64'(mem_req_ready), 64'd1);
        chk("mid_post_valid", 64'(mem_rsp_valid), 64'd0);
        req(1'b0, 8'h07, '0, 4'h0, 8'h40, 32'hDEADBEEF, 1'b1, 1'b1);
        req(1'b0, 8'h05, '0, 4'h0, 8'h41, 32'hFFFFFF00, 1'b1, 1'b1);
        drain("drain_end");
        repeat (4) @(negedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
